mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 107 ++++++++++
 tb/tb_mul_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential shift-and-add unsigned multiplier that borrows a shared external adder.
// One partial-product add per RUN cycle; iteration count follows the position of B's top set bit.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Add_Result,
    output logic [WIDTH-1:0] Add_A,
    output logic [WIDTH-1:0] Add_B,
    output logic [WIDTH-1:0] Mul_Result,
    output logic             We,
    output logic             Busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mul_result_r;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_iter_s;

    // Accumulator update: take the adder sum only when the current multiplier bit is set
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = Add_Result;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Termination needs no counter: stop once no set multiplier bits remain above bit 0
    assign last_iter_s = (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});

    // Adder operands are only driven while iterating so the shared adder sees zeros otherwise
    always_comb begin
        Add_A = {WIDTH{1'b0}};
        Add_B = {WIDTH{1'b0}};
        if (state_r == ST_RUN) begin
            Add_A = acc_r;
            Add_B = mcand_r;
        end else begin
            Add_A = {WIDTH{1'b0}};
            Add_B = {WIDTH{1'b0}};
        end
    end

    // Control and datapath state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            mcand_r      <= {WIDTH{1'b0}};
            mplier_r     <= {WIDTH{1'b0}};
            acc_r        <= {WIDTH{1'b0}};
            mul_result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (En) begin
                        if (B == {WIDTH{1'b0}}) begin
                            mul_result_r <= {WIDTH{1'b0}};
                            state_r      <= ST_DONE;
                        end else begin
                            mcand_r  <= A;
                            mplier_r <= B;
                            acc_r    <= {WIDTH{1'b0}};
                            state_r  <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    if (last_iter_s) begin
                        mul_result_r <= acc_next_s;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Mul_Result = mul_result_r;
    assign We         = (state_r == ST_DONE);
    assign Busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: behavioural product model, directed scenarios and random traffic.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] add_result;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] mul_result;
    logic        we;
    logic        busy;

    int npass  = 0;
    int ntotal = 0;

    // Model: phase 0 idle, 1 iterating, 2 result strobe
    int          ph;
    int          k;
    int          len;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_res;

    mul_seq #(.WIDTH(32)) dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .En         (en),
        .A          (a),
        .B          (b),
        .Add_Result (add_result),
        .Add_A      (add_a),
        .Add_B      (add_b),
        .Mul_Result (mul_result),
        .We         (we),
        .Busy       (busy)
    );

    assign add_result = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int msb_idx(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic reset_model();
        ph    = 0;
        k     = 0;
        len   = 0;
        m_res = 32'd0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            reset_model();
        end else begin
            case (ph)
                0: if (en) begin
                    if (b == 32'd0) begin
                        m_res = 32'd0;
                        ph    = 2;
                    end else begin
                        m_a = a;
                        m_b = b;
                        k   = 0;
                        len = msb_idx(b) + 1;
                        ph  = 1;
                    end
                end
                1: begin
                    k++;
                    if (k == len) begin
                        m_res = m_a * m_b;
                        ph    = 2;
                    end
                end
                default: ph = 0;
            endcase
        end
    endtask

    // During iteration k the accumulator holds A*(B mod 2^k) and the multiplicand is A<<k
    task automatic compare_all();
        logic [31:0] ea, eb;
        logic [63:0] mask;
        if (ph == 1) begin
            mask = (64'd1 << k) - 64'd1;
            ea   = m_a * (m_b & mask[31:0]);
            eb   = m_a << k;
        end else begin
            ea = 32'd0;
            eb = 32'd0;
        end
        chk("busy", {63'd0, busy}, (ph != 0) ? 64'd1 : 64'd0);
        chk("we", {63'd0, we}, (ph == 2) ? 64'd1 : 64'd0);
        chk("mul_result", {32'd0, mul_result}, {32'd0, m_res});
        chk("add_a", {32'd0, add_a}, {32'd0, ea});
        chk("add_b", {32'd0, add_b}, {32'd0, eb});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] lit, input int runs, input bit poke);
        int n;
        bit got;
        en = 1'b1;
        a  = op_a;
        b  = op_b;
        step();
        en  = 1'b0;
        a   = $urandom;
        b   = $urandom;
        n   = 1;
        got = 1'b0;
        while (!got && n < 100) begin
            if (we) begin
                got = 1'b1;
            end else begin
                if (poke && n == 1) begin
                    en = 1'b1;
                    a  = 32'd2;
                    b  = 32'd2;
                end else begin
                    en = 1'b0;
                end
                step();
                n++;
            end
        end
        chk("we_seen", {63'd0, got}, 64'd1);
        chk("cycles_to_we", n, runs + 1);
        chk("product_lit", {32'd0, mul_result}, {32'd0, lit});
        en = 1'b0;
        step();
        chk("we_single", {63'd0, we}, 64'd0);
        chk("result_hold", {32'd0, mul_result}, {32'd0, lit});
    endtask

    task automatic async_reset_now();
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        compare_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        m_a   = 32'd0;
        m_b   = 32'd0;
        reset_model();
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_result", {32'd0, mul_result}, 64'd0);
        chk("rst_add_a", {32'd0, add_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(32'd6, 32'd7, 32'd42, 3, 1'b0);
        run_op(32'd123, 32'd0, 32'd0, 0, 1'b0);
        run_op(32'd3, 32'h8000_0000, 32'h8000_0000, 32, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b0);
        run_op(32'd5, 32'd9, 32'd45, 4, 1'b1);
        run_op(32'd2, 32'd2, 32'd4, 2, 1'b0);

        // Abort in the second iteration cycle, then restart cleanly
        en = 1'b1;
        a  = 32'd6;
        b  = 32'd7;
        step();
        en = 1'b0;
        step();
        async_reset_now();
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_we", {63'd0, we}, 64'd0);
        chk("abort_result", {32'd0, mul_result}, 64'd0);
        run_op(32'd2, 32'd3, 32'd6, 2, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset_now();
            end else begin
                en = ($urandom_range(0, 2) == 0);
                a  = $urandom;
                b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                step();
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
